// File: rtl/dm_bus_master.sv
// dm_bus_master: MEM-stage data-memory initiator; one word-aligned valid/ready + rvalid
// transaction per lw/lh/lb/sw/sh/sb. Define DM_MASTER_TIMEOUT_EN to add the REQ/RESP watchdog.
module dm_bus_master
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  bit_type,
    input  logic        cpu_unsigned,
    output logic        stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        addr_exc,
    output logic        bus_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    // Access-size codes, matching `bit_w / `bit_h / `bit_b of the core's macro set
    localparam logic [2:0] BIT_W = 3'd0;
    localparam logic [2:0] BIT_H = 3'd1;
    localparam logic [2:0] BIT_B = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic        unsigned_q;
    logic        bus_valid_q;
    logic [31:0] bus_addr_q;
    logic        bus_we_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic        cpu_done_q;
    logic [31:0] cpu_rdata_q;
    logic        addr_exc_q;
    logic        bus_err_q;
    logic        timeout_s;
    logic        req_bad_s;
    logic [31:0] load_s;

    function automatic logic access_bad(input logic [2:0] size, input logic [1:0] off);
        case (size)
            BIT_W:   access_bad = (off != 2'b00);
            BIT_H:   access_bad = off[0];
            BIT_B:   access_bad = 1'b0;
            default: access_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] fmt_be(input logic [2:0] size, input logic [1:0] off);
        case (size)
            BIT_W:   fmt_be = 4'b1111;
            BIT_H:   fmt_be = off[1] ? 4'b1100 : 4'b0011;
            BIT_B:   fmt_be = 4'b0001 << off;
            default: fmt_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] fmt_wdata(input logic [2:0] size, input logic [31:0] data);
        case (size)
            BIT_W:   fmt_wdata = data;
            BIT_H:   fmt_wdata = {2{data[15:0]}};
            BIT_B:   fmt_wdata = {4{data[7:0]}};
            default: fmt_wdata = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [1:0] off,
                                                input logic uns, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (size)
            BIT_W:   extend_load = word;
            BIT_H:   extend_load = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            BIT_B:   extend_load = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            default: extend_load = 32'h0000_0000;
        endcase
    endfunction

    assign req_bad_s = access_bad(bit_type, cpu_addr[1:0]);
    assign load_s    = extend_load(size_q, off_q, unsigned_q, bus_rdata);

    // Reset dominates so the pipeline is released while the transaction is abandoned
    assign stall     = cpu_req & (state_q != S_DONE) & ~reset;

`ifdef DM_MASTER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_s;

    assign busy_s    = (state_q == S_REQ) || (state_q == S_RESP);
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign timeout_s = busy_s && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

    // Watchdog: restarts in IDLE, counts every cycle spent waiting on the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
        end else if (busy_s) begin
            cnt_q <= cnt_d;
        end else begin
            cnt_q <= cnt_q;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Transaction FSM with registered bus and CPU-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            off_q       <= 2'b00;
            size_q      <= 3'b000;
            unsigned_q  <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= 32'h0000_0000;
            addr_exc_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        off_q       <= cpu_addr[1:0];
                        size_q      <= bit_type;
                        unsigned_q  <= cpu_unsigned;
                        bus_addr_q  <= {cpu_addr[31:2], 2'b00};
                        bus_we_q    <= cpu_we;
                        bus_be_q    <= fmt_be(bit_type, cpu_addr[1:0]);
                        bus_wdata_q <= fmt_wdata(bit_type, cpu_wdata);
                        if (req_bad_s) begin
                            state_q    <= S_DONE;
                            cpu_done_q <= 1'b1;
                            addr_exc_q <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            bus_valid_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (timeout_s) begin
                        state_q     <= S_DONE;
                        bus_valid_q <= 1'b0;
                        cpu_done_q  <= 1'b1;
                        bus_err_q   <= 1'b1;
                    end else if (bus_ready) begin
                        state_q     <= S_RESP;
                        bus_valid_q <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (timeout_s) begin
                        state_q    <= S_DONE;
                        cpu_done_q <= 1'b1;
                        bus_err_q  <= 1'b1;
                    end else if (bus_rvalid) begin
                        state_q     <= S_DONE;
                        cpu_done_q  <= 1'b1;
                        cpu_rdata_q <= bus_we_q ? 32'h0000_0000 : load_s;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    cpu_done_q  <= 1'b0;
                    cpu_rdata_q <= 32'h0000_0000;
                    addr_exc_q  <= 1'b0;
                    bus_err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    bus_valid_q <= 1'b0;
                    cpu_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign addr_exc  = addr_exc_q;
    assign bus_err   = bus_err_q;

endmodule
